// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared types and constants for the instruction fetch stage.
// Revision : 1.0
// ============================================================================
package fetch_pkg;

  localparam int              XLEN     = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_2000;
  localparam logic [XLEN-1:0] NOP      = 32'h0000_0013;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE      = 2'd0;
  localparam fetch_state_t ST_WAIT_RESP = 2'd1;
  localparam fetch_state_t ST_HOLD      = 2'd2;
  localparam fetch_state_t ST_DRAIN     = 2'd3;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_stage_if
// Brief    : Icache request/response handshake between fetch and icache.
// Revision : 1.0
// ============================================================================
interface instr_fetch_stage_if #(
  parameter int XLEN = 32
);

  logic            icache_req_valid;
  logic            icache_req_ready;
  logic [XLEN-1:0] icache_req_addr;
  logic            icache_resp_valid;
  logic [XLEN-1:0] icache_resp_data;

  modport master (
    output icache_req_valid,
    output icache_req_addr,
    input  icache_req_ready,
    input  icache_resp_valid,
    input  icache_resp_data
  );

  modport slave (
    input  icache_req_valid,
    input  icache_req_addr,
    output icache_req_ready,
    output icache_resp_valid,
    output icache_resp_data
  );

endinterface
`default_nettype wire

// File: rtl/fetch_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_skid_reg
// Brief    : One-entry {pc,inst} buffer parking a response while decode stalls.
// Revision : 1.0
// ============================================================================
module fetch_skid_reg
  import fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  wire logic            clk,
  input  wire logic            reset_n,
  input  wire logic            load,
  input  wire logic            clear,
  input  wire logic [XLEN-1:0] pc_in,
  input  wire logic [XLEN-1:0] inst_in,
  output logic                 full,
  output logic [XLEN-1:0]      pc_out,
  output logic [XLEN-1:0]      inst_out
);

  logic            full_q, full_d;
  logic [XLEN-1:0] pc_q,   pc_d;
  logic [XLEN-1:0] inst_q, inst_d;

  always_comb begin
    full_d = full_q;
    pc_d   = pc_q;
    inst_d = inst_q;
    if (load) begin
      full_d = 1'b1;
      pc_d   = pc_in;
      inst_d = inst_in;
    end else if (clear) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_q <= 1'b0;
      pc_q   <= '0;
      inst_q <= '0;
    end else begin
      full_q <= full_d;
      pc_q   <= pc_d;
      inst_q <= inst_d;
    end
  end

  assign full     = full_q;
  assign pc_out   = pc_q;
  assign inst_out = inst_q;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_stage
// Brief    : Single-outstanding fetch sequencer feeding the IF/ID register.
// Revision : 1.0
// ============================================================================
module instr_fetch_stage
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_2000,
  parameter logic [XLEN-1:0] NOP      = 32'h0000_0013
) (
  input  wire logic            clk,
  input  wire logic            reset_n,
  input  wire logic [XLEN-1:0] pc_in,
  input  wire logic            flush,
  input  wire logic            stall,
  output logic                 pc_stall,
  instr_fetch_stage_if.master  icache,
  output logic                 if_valid,
  output logic [XLEN-1:0]      if_pc,
  output logic [XLEN-1:0]      if_inst
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [XLEN-1:0] if_inst_q, if_inst_d;

  logic            req_valid;
  logic            accept;
  logic            new_word;
  logic [XLEN-1:0] new_pc;
  logic [XLEN-1:0] new_inst;
  logic            skid_load;
  logic            skid_clear;
  logic            skid_full;
  logic [XLEN-1:0] skid_pc;
  logic [XLEN-1:0] skid_inst;

  // Gating with reset_n keeps the request low while reset is held, not just after.
  assign req_valid = reset_n && (state_q == ST_IDLE);
  assign accept    = req_valid && icache.icache_req_ready;
  assign pc_stall  = !accept && !flush;

  assign icache.icache_req_valid = req_valid;
  assign icache.icache_req_addr  = pc_in;

  always_comb begin
    state_d    = state_q;
    req_pc_d   = req_pc_q;
    new_word   = 1'b0;
    new_pc     = req_pc_q;
    new_inst   = icache.icache_resp_data;
    skid_load  = 1'b0;
    skid_clear = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          req_pc_d = pc_in;
          state_d  = flush ? ST_DRAIN : ST_WAIT_RESP;
        end
      end
      ST_WAIT_RESP: begin
        if (icache.icache_resp_valid) begin
          if (flush) begin
            state_d = ST_IDLE;
          end else if (!stall) begin
            new_word = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            skid_load = 1'b1;
            state_d   = ST_HOLD;
          end
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_HOLD: begin
        if (flush) begin
          skid_clear = 1'b1;
          state_d    = ST_IDLE;
        end else if (!stall) begin
          new_word   = skid_full;
          new_pc     = skid_pc;
          new_inst   = skid_inst;
          skid_clear = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (icache.icache_resp_valid) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Flush beats stall; an unstalled cycle without a fresh word inserts a bubble.
  always_comb begin
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    if (flush) begin
      if_valid_d = 1'b0;
    end else if (!stall) begin
      if_valid_d = new_word;
      if (new_word) begin
        if_pc_d   = new_pc;
        if_inst_d = new_inst;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      req_pc_q   <= RESET_PC;
      if_valid_q <= 1'b0;
      if_pc_q    <= RESET_PC;
      if_inst_q  <= NOP;
    end else begin
      state_q    <= state_d;
      req_pc_q   <= req_pc_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
    end
  end

  fetch_skid_reg #(
    .XLEN (XLEN)
  ) u_skid (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (skid_load),
    .clear    (skid_clear),
    .pc_in    (req_pc_q),
    .inst_in  (icache.icache_resp_data),
    .full     (skid_full),
    .pc_out   (skid_pc),
    .inst_out (skid_inst)
  );

  assign if_valid = if_valid_q;
  assign if_pc    = if_pc_q;
  assign if_inst  = if_valid_q ? if_inst_q : NOP;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_stage
// Brief    : Directed self-checking bench for instr_fetch_stage.
// Revision : 1.0
// ============================================================================
module tb_instr_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pc_in;
  logic        flush;
  logic        stall;
  logic        pc_stall;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  int n_checks = 0;
  int n_errors = 0;

  instr_fetch_stage_if #(.XLEN(32)) icache_if ();

  instr_fetch_stage dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .pc_in    (pc_in),
    .flush    (flush),
    .stall    (stall),
    .pc_stall (pc_stall),
    .icache   (icache_if),
    .if_valid (if_valid),
    .if_pc    (if_pc),
    .if_inst  (if_inst)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic resp(input logic v, input logic [31:0] d);
    icache_if.icache_resp_valid = v;
    icache_if.icache_resp_data  = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    pc_in   = 32'h0000_2000;
    flush   = 1'b0;
    stall   = 1'b0;
    icache_if.icache_req_ready = 1'b0;
    resp(1'b0, 32'h0);
    step();
    step();
    check_value("rst_req_valid", {31'd0, icache_if.icache_req_valid}, 32'd0);
    check_value("rst_if_valid",  {31'd0, if_valid}, 32'd0);
    check_value("rst_if_inst",   if_inst, 32'h0000_0013);
    check_value("rst_if_pc",     if_pc,   32'h0000_2000);
    reset_n = 1'b1;
    settle();

    // Basic fetch with a one-cycle icache
    icache_if.icache_req_ready = 1'b1;
    settle();
    check_value("t2_req_valid", {31'd0, icache_if.icache_req_valid}, 32'd1);
    check_value("t2_req_addr",  icache_if.icache_req_addr, 32'h0000_2000);
    check_value("t2_pc_stall_accept", {31'd0, pc_stall}, 32'd0);
    step();
    icache_if.icache_req_ready = 1'b0;
    pc_in = 32'h0000_2004;
    resp(1'b1, 32'h0050_0093);
    settle();
    check_value("t2_req_valid_wait", {31'd0, icache_if.icache_req_valid}, 32'd0);
    check_value("t2_pc_stall_wait",  {31'd0, pc_stall}, 32'd1);
    check_value("t2_if_valid_early", {31'd0, if_valid}, 32'd0);
    step();
    resp(1'b0, 32'h0);
    settle();
    check_value("t2_if_valid", {31'd0, if_valid}, 32'd1);
    check_value("t2_if_pc",    if_pc,   32'h0000_2000);
    check_value("t2_if_inst",  if_inst, 32'h0050_0093);

    // Icache not ready for three cycles
    for (int i = 0; i < 3; i++) begin
      check_value("t3_req_valid", {31'd0, icache_if.icache_req_valid}, 32'd1);
      check_value("t3_req_addr",  icache_if.icache_req_addr, 32'h0000_2004);
      check_value("t3_pc_stall",  {31'd0, pc_stall}, 32'd1);
      step();
    end
    check_value("t3_bubble", {31'd0, if_valid}, 32'd0);
    check_value("t3_bubble_inst", if_inst, 32'h0000_0013);

    // Response arrives under decode stall
    icache_if.icache_req_ready = 1'b1;
    settle();
    check_value("t4_pc_stall_accept", {31'd0, pc_stall}, 32'd0);
    step();
    icache_if.icache_req_ready = 1'b0;
    pc_in = 32'h0000_2008;
    stall = 1'b1;
    resp(1'b1, 32'h00A0_0113);
    settle();
    step();
    resp(1'b0, 32'h0);
    settle();
    check_value("t4_hold_req_valid", {31'd0, icache_if.icache_req_valid}, 32'd0);
    check_value("t4_hold_if_valid",  {31'd0, if_valid}, 32'd0);
    check_value("t4_hold_pc_stall",  {31'd0, pc_stall}, 32'd1);
    step();
    check_value("t4_hold2_if_valid", {31'd0, if_valid}, 32'd0);
    stall = 1'b0;
    settle();
    step();
    check_value("t4_if_valid", {31'd0, if_valid}, 32'd1);
    check_value("t4_if_inst",  if_inst, 32'h00A0_0113);
    check_value("t4_if_pc",    if_pc,   32'h0000_2004);

    // Flush while waiting; late response drained
    icache_if.icache_req_ready = 1'b1;
    settle();
    step();
    icache_if.icache_req_ready = 1'b0;
    flush = 1'b1;
    pc_in = 32'h0000_2100;
    settle();
    check_value("t5_pc_stall_flush", {31'd0, pc_stall}, 32'd0);
    step();
    flush = 1'b0;
    settle();
    check_value("t5_if_valid",  {31'd0, if_valid}, 32'd0);
    check_value("t5_drain_req", {31'd0, icache_if.icache_req_valid}, 32'd0);
    step();
    step();
    resp(1'b1, 32'hDEAD_BEEF);
    settle();
    step();
    resp(1'b0, 32'h0);
    settle();
    check_value("t5_post_if_valid", {31'd0, if_valid}, 32'd0);
    check_value("t5_post_req",      {31'd0, icache_if.icache_req_valid}, 32'd1);
    check_value("t5_post_addr",     icache_if.icache_req_addr, 32'h0000_2100);

    // Flush coincident with accept
    icache_if.icache_req_ready = 1'b1;
    flush = 1'b1;
    settle();
    check_value("t6a_pc_stall", {31'd0, pc_stall}, 32'd0);
    step();
    icache_if.icache_req_ready = 1'b0;
    flush = 1'b0;
    pc_in = 32'h0000_2200;
    resp(1'b1, 32'hBAD0_0001);
    settle();
    check_value("t6a_drain_req", {31'd0, icache_if.icache_req_valid}, 32'd0);
    step();
    resp(1'b0, 32'h0);
    settle();
    check_value("t6a_if_valid", {31'd0, if_valid}, 32'd0);
    check_value("t6a_req",      {31'd0, icache_if.icache_req_valid}, 32'd1);

    // Flush coincident with response
    icache_if.icache_req_ready = 1'b1;
    settle();
    step();
    icache_if.icache_req_ready = 1'b0;
    resp(1'b1, 32'hBAD0_0002);
    flush = 1'b1;
    pc_in = 32'h0000_2300;
    settle();
    step();
    resp(1'b0, 32'h0);
    flush = 1'b0;
    settle();
    check_value("t6b_if_valid", {31'd0, if_valid}, 32'd0);
    check_value("t6b_req",      {31'd0, icache_if.icache_req_valid}, 32'd1);
    check_value("t6b_addr",     icache_if.icache_req_addr, 32'h0000_2300);

    // Stray response in IDLE is ignored
    resp(1'b1, 32'hBAD0_0003);
    settle();
    step();
    resp(1'b0, 32'h0);
    settle();
    check_value("stray_if_valid", {31'd0, if_valid}, 32'd0);
    check_value("stray_req",      {31'd0, icache_if.icache_req_valid}, 32'd1);

    // Reset asserted mid-WAIT_RESP with a live IF/ID entry
    icache_if.icache_req_ready = 1'b1;
    settle();
    step();
    icache_if.icache_req_ready = 1'b0;
    pc_in = 32'h0000_2304;
    resp(1'b1, 32'h0000_0093);
    settle();
    step();
    resp(1'b0, 32'h0);
    stall = 1'b1;
    icache_if.icache_req_ready = 1'b1;
    settle();
    check_value("t1_live_inst", if_inst, 32'h0000_0093);
    step();
    icache_if.icache_req_ready = 1'b0;
    settle();
    check_value("t1_held_valid", {31'd0, if_valid}, 32'd1);
    check_value("t1_held_pc",    if_pc, 32'h0000_2300);
    check_value("t1_wait_req",   {31'd0, icache_if.icache_req_valid}, 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check_value("t1_rst_req",      {31'd0, icache_if.icache_req_valid}, 32'd0);
    check_value("t1_rst_if_valid", {31'd0, if_valid}, 32'd0);
    check_value("t1_rst_if_inst",  if_inst, 32'h0000_0013);
    check_value("t1_rst_if_pc",    if_pc,   32'h0000_2000);
    step();
    reset_n = 1'b1;
    stall = 1'b0;
    resp(1'b1, 32'hBAD0_0004);
    settle();
    step();
    resp(1'b0, 32'h0);
    settle();
    check_value("t1_late_if_valid", {31'd0, if_valid}, 32'd0);
    check_value("t1_late_req",      {31'd0, icache_if.icache_req_valid}, 32'd1);
    check_value("t1_late_addr",     icache_if.icache_req_addr, 32'h0000_2304);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
